// File: rtl/branch_cond_seq.sv
// Sequential RISC-V branch comparator: one CHUNK-bit slice per cycle, MSB slice first.
// Optional macro BRCOND_EARLY_EXIT_EN finishes on the first differing slice.
module branch_cond_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_ltu,
  output logic            taken,
  output logic            illegal
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            r_state;
  logic              r_init;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [2:0]        r_f3;
  logic [IW-1:0]     r_idx;
  logic              r_found;
  logic              r_ltu;
  logic              r_out_valid;
  logic              r_eq_o;
  logic              r_lt_o;
  logic              r_ltu_o;
  logic              r_taken_o;
  logic              r_illegal_o;

  logic [CHUNK-1:0]  w_s1;
  logic [CHUNK-1:0]  w_s2;
  logic              w_diff;
  logic              w_last;
  logic              w_eq_fin;
  logic              w_ltu_fin;
  logic              w_lt_fin;
  logic              w_taken;
  logic              w_illegal;
  logic              w_accept;

  always_comb begin
    w_s1 = '0;
    w_s2 = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (r_idx == IW'(i)) begin
        w_s1 = r_rs1[i*CHUNK +: CHUNK];
        w_s2 = r_rs2[i*CHUNK +: CHUNK];
      end
    end
  end

  // Final flags fold in the slice being processed this cycle.
  always_comb begin
    w_diff    = (w_s1 != w_s2);
    w_eq_fin  = !(r_found || w_diff);
    w_ltu_fin = r_found ? r_ltu : (w_diff && (w_s1 < w_s2));
    w_lt_fin  = (r_rs1[XLEN-1] != r_rs2[XLEN-1]) ? r_rs1[XLEN-1] : w_ltu_fin;
`ifdef BRCOND_EARLY_EXIT_EN
    w_last    = (r_idx == '0) || w_diff;
`else
    w_last    = (r_idx == '0);
`endif
  end

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (r_f3)
      3'b000:  w_taken = w_eq_fin;
      3'b001:  w_taken = !w_eq_fin;
      3'b100:  w_taken = w_lt_fin;
      3'b101:  w_taken = !w_lt_fin;
      3'b110:  w_taken = w_ltu_fin;
      3'b111:  w_taken = !w_ltu_fin;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    in_ready = ((r_state == IDLE) && r_init) || ((r_state == DONE) && out_ready);
    w_accept = in_valid && in_ready && !flush;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_init      <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_f3        <= '0;
      r_idx       <= '0;
      r_found     <= 1'b0;
      r_ltu       <= 1'b0;
      r_out_valid <= 1'b0;
      r_eq_o      <= 1'b0;
      r_lt_o      <= 1'b0;
      r_ltu_o     <= 1'b0;
      r_taken_o   <= 1'b0;
      r_illegal_o <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (flush) begin
        r_state     <= IDLE;
        r_rs1       <= '0;
        r_rs2       <= '0;
        r_found     <= 1'b0;
        r_ltu       <= 1'b0;
        r_out_valid <= 1'b0;
        r_eq_o      <= 1'b0;
        r_lt_o      <= 1'b0;
        r_ltu_o     <= 1'b0;
        r_taken_o   <= 1'b0;
        r_illegal_o <= 1'b0;
      end else if (w_accept) begin
        // Accept is only possible from IDLE or a released DONE; both clear the result.
        r_state     <= CMP;
        r_rs1       <= rs1;
        r_rs2       <= rs2;
        r_f3        <= funct3;
        r_idx       <= LAST_IDX;
        r_found     <= 1'b0;
        r_ltu       <= 1'b0;
        r_out_valid <= 1'b0;
        r_eq_o      <= 1'b0;
        r_lt_o      <= 1'b0;
        r_ltu_o     <= 1'b0;
        r_taken_o   <= 1'b0;
        r_illegal_o <= 1'b0;
      end else begin
        case (r_state)
          CMP: begin
            r_idx <= r_idx - 1'b1;
            if (!r_found && w_diff) begin
              r_found <= 1'b1;
              r_ltu   <= (w_s1 < w_s2);
            end
            if (w_last) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_eq_o      <= w_eq_fin;
              r_lt_o      <= w_lt_fin;
              r_ltu_o     <= w_ltu_fin;
              r_taken_o   <= w_taken;
              r_illegal_o <= w_illegal;
            end
          end
          DONE: begin
            if (out_ready) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_eq_o      <= 1'b0;
              r_lt_o      <= 1'b0;
              r_ltu_o     <= 1'b0;
              r_taken_o   <= 1'b0;
              r_illegal_o <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    out_valid = r_out_valid;
    br_eq     = r_eq_o;
    br_lt     = r_lt_o;
    br_ltu    = r_ltu_o;
    taken     = r_taken_o;
    illegal   = r_illegal_o;
  end

endmodule

// File: tb/tb_branch_cond_seq.sv
// Directed self-checking bench for branch_cond_seq (XLEN=32, CHUNK=8).
module tb_branch_cond_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        taken;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        tk;
    logic        ill;
    int          lat_def;
    int          lat_early;
  } vec_t;

  branch_cond_seq #(.XLEN(32), .CHUNK(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .br_ltu    (br_ltu),
    .taken     (taken),
    .illegal   (illegal)
  );

  always #5 CLK = ~CLK;

  // Drive one request, then scramble operand inputs after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    @(negedge CLK);
    in_valid  = 1'b1;
    rs1       = a;
    rs2       = b;
    funct3    = f;
    out_ready = 1'b0;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    rs1      = ~a;
    rs2      = a ^ 32'h5A5A_A5A5;
    funct3   = ~f;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (out_valid === 1'b1) seen++;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rs1 = '0; rs2 = '0; funct3 = '0;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal});
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=0", in_ready);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_edge got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors;
    vec_t v[8];
    int   lat;
    int   exp_lat;
    v[0] = '{32'h0000_0005, 32'h0000_0005, 3'b000, 1, 0, 0, 1, 0, 4, 4};
    v[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, 1, 0, 1, 0, 4, 1};
    v[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, 1, 0, 0, 0, 4, 1};
    v[3] = '{32'h1234_5600, 32'h1234_5601, 3'b110, 0, 1, 1, 1, 0, 4, 4};
    v[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0, 1, 0, 0, 0, 4, 1};
    v[5] = '{32'h0001_0000, 32'h0002_0000, 3'b001, 0, 1, 1, 1, 0, 4, 2};
    v[6] = '{32'h0000_0005, 32'h0000_0005, 3'b111, 1, 0, 0, 1, 0, 4, 4};
    v[7] = '{32'h1234_0000, 32'h1233_0000, 3'b010, 0, 0, 0, 0, 1, 4, 2};
    for (int unsigned i = 0; i < 8; i++) begin
`ifdef BRCOND_EARLY_EXIT_EN
      exp_lat = v[i].lat_early;
`else
      exp_lat = v[i].lat_def;
`endif
      start_op(v[i].a, v[i].b, v[i].f);
      wait_result(lat);
      checks++;
      if (lat != exp_lat) begin
        failures++;
        $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, exp_lat);
      end
      checks++;
      if ({out_valid, br_eq, br_lt, br_ltu, taken, illegal} !==
          {1'b1, v[i].eq, v[i].lt, v[i].ltu, v[i].tk, v[i].ill}) begin
        failures++;
        $display("FAIL vec%0d_result got v/eq/lt/ltu/tk/ill=%b exp=%b", i,
                 {out_valid, br_eq, br_lt, br_ltu, taken, illegal},
                 {1'b1, v[i].eq, v[i].lt, v[i].ltu, v[i].tk, v[i].ill});
      end
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      checks++;
      if ({out_valid, br_eq, br_lt, br_ltu, taken, illegal, in_ready} !== 7'b0000001) begin
        failures++;
        $display("FAIL vec%0d_release got v/eq/lt/ltu/tk/ill/rdy=%b exp=0000001", i,
                 {out_valid, br_eq, br_lt, br_ltu, taken, illegal, in_ready});
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
    wait_result(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({out_valid, br_eq, br_lt, br_ltu, taken, illegal, in_ready} !== 7'b1010100) begin
        failures++;
        $display("FAIL hold%0d got v/eq/lt/ltu/tk/ill/rdy=%b exp=1010100", i,
                 {out_valid, br_eq, br_lt, br_ltu, taken, illegal, in_ready});
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    rs1 = 32'h0000_0007; rs2 = 32'h0000_0007; funct3 = 3'b000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got=%b exp=1", in_ready);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    rs1 = 32'hDEAD_BEEF; rs2 = 32'h0; funct3 = 3'b001;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_in_cmp got valid=%b ready=%b exp 0 0", out_valid, in_ready);
    end
    wait_result(lat);
    checks++;
    if (lat != 4 || {br_eq, br_lt, br_ltu, taken, illegal} !== 5'b10010) begin
      failures++;
      $display("FAIL b2b_result got lat=%0d flags=%b exp lat=4 flags=10010",
               lat, {br_eq, br_lt, br_ltu, taken, illegal});
    end
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    int seen;
    int lat;
    start_op(32'h0000_0009, 32'h0000_0009, 3'b000);
    @(posedge CLK);
    #1;
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_cmp got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    end
    count_valid(6, seen);
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_no_pulse got=%0d exp=0", seen);
    end
    flush = 1'b1; in_valid = 1'b1;
    rs1 = 32'h1; rs2 = 32'h1; funct3 = 3'b000;
    @(posedge CLK);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    count_valid(6, seen);
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_over_accept got=%0d exp=0", seen);
    end
    start_op(32'h0000_0003, 32'h0000_0004, 3'b110);
    wait_result(lat);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    checks++;
    if ({out_valid, taken, br_ltu, in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL flush_done got v/tk/ltu/rdy=%b exp=0001", {out_valid, taken, br_ltu, in_ready});
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    int lat;
    start_op(32'h0000_0009, 32'h0000_0009, 3'b000);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal} !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid_cmp got=%b exp=0000000",
               {in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    count_valid(6, seen);
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_no_pulse got pulses=%0d ready=%b exp 0 1", seen, in_ready);
    end
    start_op(32'h0000_0005, 32'h0000_0005, 3'b000);
    wait_result(lat);
    RST_N = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal} !== 7'b0) begin
      failures++;
      $display("FAIL rst_in_done got=%b exp=0000000",
               {in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_done_release got ready=%b valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_cond_seq.md
BRANCH_COND_SEQ -- requirements
Module: branch_cond_seq

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits compared per cycle; XLEN SHALL be an integer multiple of CHUNK; NCHUNK = XLEN/CHUNK.
REQ-003 Clock and reset: one clock, CLK; reset is asynchronous and active-low, RST_N.
REQ-004 CLK  in  1  rising-edge clock for all state.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  request present; in_ready  out  1  unit can accept.
REQ-007 rs1, rs2  in  XLEN each  operands, sampled on accept only.
REQ-008 funct3  in  3  RISC-V branch funct3, sampled on accept.
REQ-009 flush  in  1  synchronous abort of any in-flight or held result.
REQ-010 out_valid  out  1  result valid; out_ready  in  1  consumer takes result.
REQ-011 br_eq, br_lt, br_ltu  out  1 each  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.
REQ-012 taken  out  1  branch decision; illegal  out  1  funct3 is 010 or 011.

Function
REQ-013 States SHALL be IDLE, CMP, DONE.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, else 0.
REQ-015 Accept (in_valid & in_ready at an edge) SHALL latch rs1, rs2, funct3, clear chunk index to NCHUNK-1 and enter CMP.
REQ-016 Each CMP cycle SHALL compare one CHUNK-bit slice, MSB slice first, index decrementing.
REQ-017 First differing slice SHALL fix ltu = (rs1 slice < rs2 slice unsigned) and eq = 0; no differing slice gives eq=1, ltu=0.
REQ-018 lt SHALL equal rs1[XLEN-1] when operand sign bits differ, else ltu.
REQ-019 CMP SHALL transition to DONE on the edge processing slice index 0; out_valid therefore rises NCHUNK cycles after the accept edge.
REQ-020 taken SHALL decode funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu, 010/011 taken=0 and illegal=1.
REQ-021 In DONE all result outputs SHALL hold stable until out_ready=1.
REQ-022 DONE with out_ready=1 and no accept SHALL go to IDLE; with simultaneous accept SHALL go directly to CMP (no bubble).
REQ-023 Result outputs SHALL be 0 whenever out_valid=0.
REQ-024 flush=1 SHALL force IDLE at next edge from any state, discard operands, take priority over accept, and drop out_valid.
REQ-025 Input changes on rs1/rs2/funct3 after accept SHALL not affect the in-flight result.

Reset
REQ-026 RST_N low SHALL immediately force IDLE, out_valid=0, all result outputs 0, in_ready=0.
REQ-027 in_ready SHALL go 1 on the first edge after RST_N deasserts; reset mid-compare SHALL discard the operation without any out_valid pulse.

Configuration
REQ-028 Macro BRCOND_EARLY_EXIT_EN defined: CMP SHALL enter DONE on the edge processing the first differing slice; latency = 1 + (NCHUNK-1 - differing index) cycles, equal operands still NCHUNK.
REQ-029 Macro undefined: latency SHALL be exactly NCHUNK cycles for every operand pair; results identical in both builds.

Verification (XLEN=32, CHUNK=8)
REQ-030 rs1=rs2=0x0000_0005, funct3=000 -> out_valid 4 cycles after accept, br_eq=1, br_lt=0, br_ltu=0, taken=1.
REQ-031 rs1=0xFFFF_FFFF, rs2=0x0000_0001, funct3=100 -> br_lt=1, br_ltu=0, taken=1; latency 1 cycle with BRCOND_EARLY_EXIT_EN, 4 without; funct3=110 -> taken=0.
REQ-032 funct3=010, any operands -> illegal=1, taken=0, out_valid still asserted.
REQ-033 Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same edge, next result 4 cycles later.
REQ-034 flush=1 on second CMP cycle -> IDLE next edge, no out_valid pulse, in_ready=1; repeat with RST_N low mid-CMP -> all outputs 0 immediately.
